// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, states, ALU/mux selects.
// Also defines the packed control word passed from the output decoder to the top.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] ALUSRCB_B   = 2'b00;
  localparam logic [1:0] ALUSRCB_4   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM = 2'b10;
  localparam logic [1:0] ALUSRCB_BR  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_BEQ_EX   = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ORI_EX   = 4'd11,
    S_IMM_WB   = 4'd12,
    S_JUMP     = 4'd13,
    S_TRAP     = 4'd14
  } state_e;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       trap;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mc_output_decode.sv
// Pure state-to-control-word decoder; zero latency, no handshake.
// Unlisted and unreachable encodings decode to an all-zero (idle) word.
module mc_output_decode
  import mc_pkg::*;
(
  input  logic [3:0]        state_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  ctrl_t c;

  always_comb begin
    c = '0;
    case (state_e'(state_i))
      S_FETCH: begin
        c.memread = 1'b1;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.alusrcb = ALUSRCB_4;
        c.aluop   = ALUOP_ADD;
        c.pcsrc   = PCSRC_ALU;
      end
      S_DECODE: begin
        c.alusrcb = ALUSRCB_BR;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        c.alusrca = 1'b1;
        c.alusrcb = ALUSRCB_IMM;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_RTYPE_EX: begin
        c.alusrca = 1'b1;
        c.alusrcb = ALUSRCB_B;
        c.aluop   = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      S_BEQ_EX: begin
        c.alusrca     = 1'b1;
        c.alusrcb     = ALUSRCB_B;
        c.aluop       = ALUOP_SUB;
        c.pcwritecond = 1'b1;
        c.pcsrc       = PCSRC_ALUOUT;
      end
      S_ORI_EX: begin
        c.alusrca = 1'b1;
        c.alusrcb = ALUSRCB_IMM;
        c.zeroext = 1'b1;
        c.aluop   = ALUOP_OR;
      end
      S_IMM_WB: c.regwrite = 1'b1;
      S_JUMP: begin
        c.pcwrite = 1'b1;
        c.pcsrc   = PCSRC_JUMP;
      end
      S_TRAP:  c.trap = 1'b1;
      default: c = '0;
    endcase
  end

  assign ctrl_o = c;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with sticky illegal-opcode trap and retired-instruction counter.
// Stalls in FETCH/MEMRD/MEMWR until mem_ready; outputs follow state, only FETCH's PC/IR loads wait on mem_ready.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             memtoreg,
  output logic             regdst,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic             zeroext,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic             trap,
  output logic [CNT_W-1:0] instr_count
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CTRL_W-1:0]  ctrl_w;
  ctrl_t              ctrl;
  logic               retire;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     state_d = S_RTYPE_EX;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQ_EX;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_ORI:       state_d = S_ORI_EX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:    if (mem_ready) state_d = S_FETCH;
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_ADDI_EX,
      S_ORI_EX:   state_d = S_IMM_WB;
      S_MEMWB, S_RTYPE_WB, S_BEQ_EX, S_IMM_WB, S_JUMP:
                  state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_IDLE;
    endcase
  end

  // Every arc into FETCH except IDLE start-up and a FETCH stall ends an instruction.
  assign retire = (state_d == S_FETCH) && (state_q != S_IDLE) && (state_q != S_FETCH);
  assign cnt_d  = retire ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mc_output_decode u_decode (
    .state_i (state_q),
    .ctrl_o  (ctrl_w)
  );

  assign ctrl = ctrl_w;

  // PC increment and IR load must fire once, on the cycle the fetch read completes.
  assign pcwrite     = ctrl.pcwrite & ((state_q != S_FETCH) | mem_ready);
  assign irwrite     = ctrl.irwrite & mem_ready;
  assign pcwritecond = ctrl.pcwritecond;
  assign iord        = ctrl.iord;
  assign memread     = ctrl.memread;
  assign memwrite    = ctrl.memwrite;
  assign memtoreg    = ctrl.memtoreg;
  assign regdst      = ctrl.regdst;
  assign regwrite    = ctrl.regwrite;
  assign alusrca     = ctrl.alusrca;
  assign alusrcb     = ctrl.alusrcb;
  assign zeroext     = ctrl.zeroext;
  assign aluop       = ctrl.aluop;
  assign pcsrc       = ctrl.pcsrc;
  assign trap        = ctrl.trap;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected control sequences built from the state table,
// random opcodes and memory wait states, counter tracked as retired-instruction total modulo 2^CW.
module tb_multicycle_control;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [5:0]    op = '0;
  logic          mem_ready = 1'b0;
  logic          pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic          memtoreg, regdst, regwrite, alusrca, zeroext, trap;
  logic [1:0]    alusrcb, aluop, pcsrc;
  logic [CW-1:0] instr_count;

  int passed = 0;
  int total  = 0;
  logic [CW-1:0] exp_cnt = '0;

  logic [18:0] obs;
  assign obs = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
                regwrite, alusrca, alusrcb, zeroext, aluop, pcsrc, trap};

  multicycle_control #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext),
    .aluop(aluop), .pcsrc(pcsrc), .trap(trap), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] mk(bit pcw, bit pcwc, bit io, bit mrd, bit mwr, bit irw,
                                     bit m2r, bit rdst, bit rw, bit asa, logic [1:0] asb,
                                     bit zx, logic [1:0] aop, logic [1:0] psrc, bit trp);
    return {pcw, pcwc, io, mrd, mwr, irw, m2r, rdst, rw, asa, asb, zx, aop, psrc, trp};
  endfunction

  logic [18:0] E_ZERO, E_FETCH, E_FWAIT, E_DECODE, E_ADR, E_MEMRD, E_MEMWB, E_MEMWR;
  logic [18:0] E_REX, E_RWB, E_BEQ, E_ORI, E_IWB, E_JUMP, E_TRAP;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  // One clock of stimulus: drive at negedge, check just after, then let the posedge act.
  task automatic step(input logic mr, input logic [5:0] o, input logic [18:0] e,
                      input bit retire, input string tag);
    @(negedge clk);
    mem_ready = mr;
    op = o;
    #1;
    check({tag, "_ctrl"}, 32'(obs), 32'(e));
    check({tag, "_cnt"}, 32'(instr_count), 32'(exp_cnt));
    if (retire) exp_cnt = exp_cnt + 1'b1;
  endtask

  // Called just after a check point (negedge+1); reset lands mid-cycle and must act at once.
  task automatic do_reset();
    #3 rst = 1'b0;
    #1;
    check("rst_async_ctrl", 32'(obs), 32'(E_ZERO));
    check("rst_async_cnt", 32'(instr_count), 32'd0);
    exp_cnt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check("rst_hold_ctrl", 32'(obs), 32'(E_ZERO));
    rst = 1'b1;
    #1;
    check("idle_ctrl", 32'(obs), 32'(E_ZERO));
    check("idle_cnt", 32'(instr_count), 32'd0);
  endtask

  task automatic run_instr(input logic [5:0] o, input int fw, input int mw, input bit abort);
    for (int i = 0; i < fw; i++) step(1'b0, 6'($urandom), E_FWAIT, 1'b0, "fetch_wait");
    step(1'b1, 6'($urandom), E_FETCH, 1'b0, "fetch");
    step(1'($urandom), o, E_DECODE, 1'b0, "decode");
    case (o)
      6'b000000: begin
        step(1'($urandom), o, E_REX, 1'b0, "rtype_ex");
        step(1'($urandom), o, E_RWB, 1'b1, "rtype_wb");
      end
      6'b100011: begin
        step(1'($urandom), o, E_ADR, 1'b0, "lw_adr");
        for (int i = 0; i < mw; i++) step(1'b0, o, E_MEMRD, 1'b0, "memrd_wait");
        step(1'b1, o, E_MEMRD, 1'b0, "memrd");
        step(1'($urandom), o, E_MEMWB, 1'b1, "memwb");
      end
      6'b101011: begin
        step(1'($urandom), o, E_ADR, 1'b0, "sw_adr");
        if (abort) begin
          step(1'b0, o, E_MEMWR, 1'b0, "memwr_wait");
          do_reset();
        end else begin
          for (int i = 0; i < mw; i++) step(1'b0, o, E_MEMWR, 1'b0, "memwr_wait");
          step(1'b1, o, E_MEMWR, 1'b1, "memwr");
        end
      end
      6'b000100: step(1'($urandom), o, E_BEQ, 1'b1, "beq_ex");
      6'b001000: begin
        step(1'($urandom), o, E_ADR, 1'b0, "addi_ex");
        step(1'($urandom), o, E_IWB, 1'b1, "addi_wb");
      end
      6'b001101: begin
        step(1'($urandom), o, E_ORI, 1'b0, "ori_ex");
        step(1'($urandom), o, E_IWB, 1'b1, "ori_wb");
      end
      6'b000010: step(1'($urandom), o, E_JUMP, 1'b1, "jump");
      default: begin
        for (int i = 0; i < 10; i++) step(1'($urandom), 6'($urandom), E_TRAP, 1'b0, "trap");
        do_reset();
      end
    endcase
  endtask

  logic [5:0] legal_ops [7];
  logic [5:0] bad;

  initial begin
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b001101, 6'b000010};
    E_ZERO   = '0;
    //            pcw pcwc io mrd mwr irw m2r rdst rw asa asb    zx aop    psrc   trp
    E_FETCH  = mk(1,  0,   0, 1,  0,  1,  0,  0,   0, 0,  2'b01, 0, 2'b00, 2'b00, 0);
    E_FWAIT  = mk(0,  0,   0, 1,  0,  0,  0,  0,   0, 0,  2'b01, 0, 2'b00, 2'b00, 0);
    E_DECODE = mk(0,  0,   0, 0,  0,  0,  0,  0,   0, 0,  2'b11, 0, 2'b00, 2'b00, 0);
    E_ADR    = mk(0,  0,   0, 0,  0,  0,  0,  0,   0, 1,  2'b10, 0, 2'b00, 2'b00, 0);
    E_MEMRD  = mk(0,  0,   1, 1,  0,  0,  0,  0,   0, 0,  2'b00, 0, 2'b00, 2'b00, 0);
    E_MEMWB  = mk(0,  0,   0, 0,  0,  0,  1,  0,   1, 0,  2'b00, 0, 2'b00, 2'b00, 0);
    E_MEMWR  = mk(0,  0,   1, 0,  1,  0,  0,  0,   0, 0,  2'b00, 0, 2'b00, 2'b00, 0);
    E_REX    = mk(0,  0,   0, 0,  0,  0,  0,  0,   0, 1,  2'b00, 0, 2'b10, 2'b00, 0);
    E_RWB    = mk(0,  0,   0, 0,  0,  0,  0,  1,   1, 0,  2'b00, 0, 2'b00, 2'b00, 0);
    E_BEQ    = mk(0,  1,   0, 0,  0,  0,  0,  0,   0, 1,  2'b00, 0, 2'b01, 2'b01, 0);
    E_ORI    = mk(0,  0,   0, 0,  0,  0,  0,  0,   0, 1,  2'b10, 1, 2'b11, 2'b00, 0);
    E_IWB    = mk(0,  0,   0, 0,  0,  0,  0,  0,   1, 0,  2'b00, 0, 2'b00, 2'b00, 0);
    E_JUMP   = mk(1,  0,   0, 0,  0,  0,  0,  0,   0, 0,  2'b00, 0, 2'b00, 2'b10, 0);
    E_TRAP   = mk(0,  0,   0, 0,  0,  0,  0,  0,   0, 0,  2'b00, 0, 2'b00, 2'b00, 1);

    @(negedge clk);
    #1;
    do_reset();

    // Directed: R-type, lw with two MEMRD stalls, beq, j.
    run_instr(6'b000000, 0, 0, 1'b0);
    run_instr(6'b100011, 0, 2, 1'b0);
    run_instr(6'b000100, 0, 0, 1'b0);
    run_instr(6'b000010, 0, 0, 1'b0);

    // Random legal mix with random fetch and memory stalls; counter wraps several times.
    for (int n = 0; n < 40; n++)
      run_instr(legal_ops[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);

    // sw aborted by reset while waiting in MEMWR, then restart.
    run_instr(6'b101011, 1, 0, 1'b1);
    for (int n = 0; n < 10; n++)
      run_instr(legal_ops[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);

    // Illegal opcodes: directed 111111, then a random one.
    run_instr(6'b111111, 0, 0, 1'b0);
    run_instr(6'b000000, 0, 0, 1'b0);
    bad = 6'($urandom);
    while (bad inside {legal_ops}) bad = 6'($urandom);
    run_instr(legal_ops[$urandom_range(0, 6)], 1, 1, 1'b0);
    run_instr(bad, 0, 0, 1'b0);
    run_instr(6'b001101, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
